uart_comm: RTL and testbench
============================

Name: uart_comm

Overview:
Host-side command/response transport that sits directly upstream of the digital core.
- Deserialises the 8N1 UART RX line into 3-byte host commands and presents them as a 24-bit cmd with a cmd_rdy/clr_cmd_rdy handshake.
- Serialises the core's single-byte responses onto TX on send_resp and signals resp_sent on completion.
- One instance per scope, clocked by the system clock.

Parameters:
BAUD_DIV, 2604, system clocks per UART bit (100 MHz / 38400); minimum 4.
TIMEOUT_CYC, 1000000, inter-byte gap limit in clocks; used only with the optional feature.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  UART serial in, asynchronous to clk
TX  output  1  UART serial out, idle high
cmd  output  24  assembled command: byte0 in [23:16], byte1 in [15:8], byte2 in [7:0]
cmd_rdy  output  1  cmd valid; held until cleared
clr_cmd_rdy  input  1  core acknowledges cmd; clears cmd_rdy
resp_data  input  8  response byte to transmit
send_resp  input  1  1-cycle request to transmit resp_data
resp_sent  output  1  1-cycle pulse when the stop bit of a response finishes

Behaviour:
Interface rule: one clock; reset is asynchronous and active-low (clk, rst_n).

Reset values:
- TX=1, cmd=0, cmd_rdy=0, resp_sent=0.
- Byte index=0; both state machines in IDLE.

RX synchronisation:
- RX passes through 2 flops, then a third flop for edge detection.
- A falling edge in IDLE starts reception.

RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- START: wait BAUD_DIV/2 clocks and re-sample. If RX=1, treat as a glitch and return to IDLE.
- DATA: sample every BAUD_DIV clocks, 8 bits, LSB first, into a shift register.
- STOP: sample after BAUD_DIV clocks.
  - Stop bit = 1: byte is valid.
  - Stop bit = 0 (framing error): byte is discarded, byte index reset to 0, FSM waits for RX=1 before returning to IDLE.

Frame assembly:
- Valid bytes fill a shadow register at byte index 0, 1, 2.
- When byte 2 completes, cmd loads the shadow register and cmd_rdy sets on the next clock edge.
- Latency: last stop-bit sample to cmd_rdy=1 is 1 clock.
- Byte index wraps to 0 after each frame.
- cmd is stable whenever cmd_rdy=1.

Handshake:
- clr_cmd_rdy=1 clears cmd_rdy on the next edge; cmd retains its value.
- A frame that completes while cmd_rdy=1 and clr_cmd_rdy=0 is dropped and cmd is unchanged.
- A frame that completes in the same cycle as clr_cmd_rdy=1 is loaded, and cmd_rdy stays 1.

TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- send_resp in IDLE latches resp_data and enters START on the next clock.
- Each bit lasts BAUD_DIV clocks: 0 start bit, 8 data bits LSB first, 1 stop bit.
- resp_sent pulses 1 clock as STOP ends; TX returns to IDLE in the same cycle.
- send_resp while not IDLE is ignored; no queueing.
- A send_resp arriving in the same cycle as resp_sent is also ignored.

RX and TX are fully independent (full duplex).

Reset asserted mid-frame or mid-byte:
- Everything returns to reset values immediately.
- A partial frame is lost.
- TX drives 1 immediately.

Optional Feature:
Macro: UART_COMM_TIMEOUT_EN.
- Defined: a counter runs while byte index is nonzero and RX is idle. When it reaches TIMEOUT_CYC, byte index resets to 0 and the shadow register clears. This resynchronises after a lost byte. The counter resets on every valid byte.
- Undefined: no counter; frames span arbitrary gaps and TIMEOUT_CYC is unused.

Decomposition:
- Package uart_comm_pkg holds:
  - RX and TX state enums (IDLE, START, DATA, STOP);
  - BITS_PER_BYTE=8 and BYTES_PER_CMD=3;
  - byte-lane constants for cmd.
- The bit-level receiver is a natural sub-module, uart_rx, outputting rx_byte, rx_valid and framing_err.
- Frame assembly, handshake and the TX FSM stay in uart_comm.

Test Plan:
All scenarios run with BAUD_DIV=8 and TIMEOUT_CYC=200.
1. Send bytes 0x12, 0x34, 0x56 on RX -> cmd=0x123456, cmd_rdy=1 one clock after the third stop sample; assert clr_cmd_rdy -> cmd_rdy=0 next clock, cmd still 0x123456.
2. With cmd_rdy=1 and no clear, send 0xAA, 0xBB, 0xCC -> cmd stays 0x123456; then clear in the same cycle that a following frame 0x01, 0x02, 0x03 completes -> cmd=0x010203, cmd_rdy=1.
3. send_resp with resp_data=0xA5 -> TX carries 0, 1,0,1,0,0,1,0,1, 1, each bit 8 clocks; resp_sent pulses at clock 80; a send_resp issued at clock 40 produces no extra byte.
4. Byte with stop bit forced 0 mid-frame (0x11, bad, 0x22, 0x33, 0x44) -> the bad byte resets the index; cmd=0x223344.
5. 2-clock low glitch on idle RX -> no byte, no cmd_rdy; assert rst_n=0 mid-TX -> TX=1 and FSMs IDLE immediately.
6. With UART_COMM_TIMEOUT_EN: send 0x77, gap of 300 clocks, then 0x01, 0x02, 0x03 -> cmd=0x010203. Without the macro, the same stimulus gives cmd=0x770102.

Source files
------------

// File: rtl/uart_comm_pkg.sv
// uart_comm_pkg: shared constants, FSM state codes and the command byte-lane
// helper for the uart_comm host transport.
package uart_comm_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BYTES_PER_CMD = 3;
    localparam int CMD_W         = BITS_PER_BYTE * BYTES_PER_CMD;

    // Byte lanes of the assembled command: byte0 is the first byte received.
    localparam int BYTE0_LSB = 16;
    localparam int BYTE1_LSB = 8;
    localparam int BYTE2_LSB = 0;

    // Index of the byte that completes a command.
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_CMD - 1);

    // Receiver state codes.
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Transmitter state codes.
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Returns word with byte b written into the lane selected by idx.
    function automatic logic [CMD_W-1:0] put_lane(
        input logic [CMD_W-1:0]         word,
        input logic [1:0]               idx,
        input logic [BITS_PER_BYTE-1:0] b
    );
        logic [CMD_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[BYTE0_LSB +: BITS_PER_BYTE] = b;
            2'd1:    res[BYTE1_LSB +: BITS_PER_BYTE] = b;
            default: res[BYTE2_LSB +: BITS_PER_BYTE] = b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 bit-level receiver. Synchronises the asynchronous RX line,
// rejects short start-bit glitches, and reports each byte as either a
// one-cycle o_rx_valid or a one-cycle o_framing_err. After a framing error
// the receiver holds off until the line has returned high.
module uart_rx
    import uart_comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_rx,
    output logic [BITS_PER_BYTE-1:0] o_rx_byte,
    output logic                     o_rx_valid,
    output logic                     o_framing_err,
    output logic                     o_rx_busy
);

    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic                     r_rx_meta;
    logic                     r_rx_sync;
    logic                     r_rx_prev;
    logic                     w_fall;
    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [2:0]               r_bit;
    logic [BITS_PER_BYTE-1:0] r_shift;
    logic                     r_wait_high;
    logic                     r_valid;
    logic                     r_ferr;

    // Two synchroniser flops, then a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the values present before the clock edge.
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // Receive FSM: mid-bit sampling of start, 8 data bits LSB first, stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_END) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_END) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[BITS_PER_BYTE-1:1]};
                        if (r_bit == LAST_BIT) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_wait_high) begin
                        // Broken frame: wait for the line to idle before re-arming.
                        if (r_rx_sync) begin
                            r_wait_high <= 1'b0;
                            r_state     <= RX_IDLE;
                        end
                    end else if (r_cnt == BIT_END) begin
                        r_cnt <= '0;
                        if (r_rx_sync) begin
                            r_valid <= 1'b1;
                            r_state <= RX_IDLE;
                        end else begin
                            r_ferr      <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_rx_byte     = r_shift;
    assign o_rx_valid    = r_valid;
    assign o_framing_err = r_ferr;
    assign o_rx_busy     = (r_state != RX_IDLE);

endmodule

// File: rtl/uart_comm.sv
// uart_comm: host-side UART command/response transport.
// RX bytes are assembled into 3-byte commands presented on cmd with a
// cmd_rdy/clr_cmd_rdy handshake; single response bytes are serialised on TX.
// Optional build macro UART_COMM_TIMEOUT_EN: an inter-byte gap longer than
// TIMEOUT_CYC clocks discards a partially assembled command.
module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RX,
    output logic                     TX,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_rdy,
    input  logic                     clr_cmd_rdy,
    input  logic [BITS_PER_BYTE-1:0] resp_data,
    input  logic                     send_resp,
    output logic                     resp_sent
);

    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic [BITS_PER_BYTE-1:0] w_rx_byte;
    logic                     w_rx_valid;
    logic                     w_framing_err;
    logic                     w_rx_busy;
    logic                     w_timeout;
    logic                     w_frame_done;
    logic [CMD_W-1:0]         w_full_cmd;

    logic [1:0]               r_idx;
    logic [CMD_W-1:0]         r_shadow;
    logic [CMD_W-1:0]         r_cmd;
    logic                     r_cmd_rdy;

    logic [1:0]               r_tx_state;
    logic [CNT_W-1:0]         r_tx_cnt;
    logic [2:0]               r_tx_bit;
    logic [BITS_PER_BYTE-1:0] r_tx_shift;
    logic                     r_tx;
    logic                     r_resp_sent;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx          (RX),
        .o_rx_byte     (w_rx_byte),
        .o_rx_valid    (w_rx_valid),
        .o_framing_err (w_framing_err),
        .o_rx_busy     (w_rx_busy)
    );

`ifdef UART_COMM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Gap counter: runs while a command is partially assembled and RX is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_idx == 2'd0 || w_rx_valid || w_timeout) begin
            r_to_cnt <= '0;
        end else if (!w_rx_busy) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
    // Without the timeout the receiver busy flag and TIMEOUT_CYC have no consumer.
    logic w_unused_to;
    assign w_unused_to = w_rx_busy ^ (TIMEOUT_CYC > 0);
    assign w_timeout   = 1'b0;
`endif

    assign w_full_cmd   = put_lane(r_shadow, r_idx, w_rx_byte);
    assign w_frame_done = w_rx_valid && (r_idx == LAST_IDX);

    // Byte index and shadow register: place each valid byte in its lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_shadow <= '0;
        end else if (w_rx_valid) begin
            r_shadow <= w_full_cmd;
            r_idx    <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 1'b1;
        end else if (w_framing_err) begin
            r_idx <= '0;
        end else if (w_timeout) begin
            r_idx    <= '0;
            r_shadow <= '0;
        end
    end

    // Command handshake: load when free or being cleared, else drop the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else if (w_frame_done && (!r_cmd_rdy || clr_cmd_rdy)) begin
            r_cmd     <= w_full_cmd;
            r_cmd_rdy <= 1'b1;
        end else if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
        end
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, then resp_sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx        <= 1'b1;
            r_resp_sent <= 1'b0;
        end else begin
            r_resp_sent <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    // The cycle that reports completion is not yet open for a new request.
                    if (send_resp && !r_resp_sent) begin
                        r_tx_shift <= resp_data;
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx       <= r_tx_shift[1];
                            r_tx_shift <= {1'b0, r_tx_shift[BITS_PER_BYTE-1:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_tx_cnt == BIT_END) begin
                        r_tx_cnt    <= '0;
                        r_resp_sent <= 1'b1;
                        r_tx_state  <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign TX        = r_tx;
    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_uart_comm.sv
// tb_uart_comm: self-checking bench for uart_comm (BAUD_DIV=8, TIMEOUT_CYC=200).
// A frame-level reference model (byte index, three byte slots, cmd, cmd_rdy)
// predicts the command interface; TX is compared against the ideal 8N1
// waveform bit by bit. Inputs change and outputs are sampled on negedges.
module tb_uart_comm;

    localparam int BAUD  = 8;
    localparam int TOUT  = 200;
    localparam int FRAME = 10 * BAUD;
    // Two synchroniser flops plus the edge flop before the receiver reacts.
    localparam int SYNC_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr;
    logic [7:0]  resp_data;
    logic        send;
    logic        resp_sent;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state.
    int          m_idx;
    logic [7:0]  m_sh [3];
    logic [23:0] m_cmd;
    logic        m_rdy;

    uart_comm #(
        .BAUD_DIV    (BAUD),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx),
        .TX          (tx),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr),
        .resp_data   (resp_data),
        .send_resp   (send),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cmd"}, {8'h0, cmd}, {8'h0, m_cmd});
        check({tag, "_rdy"}, {31'h0, cmd_rdy}, {31'h0, m_rdy});
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_cmd = '0;
        m_rdy = 1'b0;
        for (int i = 0; i < 3; i++) m_sh[i] = '0;
    endtask

    // Idle line for cyc clocks; a long enough gap discards a partial command
    // when the timeout feature is built in.
    task automatic idle(input int cyc);
        rx = 1'b1;
        repeat (cyc) @(negedge clk);
`ifdef UART_COMM_TIMEOUT_EN
        if (m_idx != 0 && cyc > TOUT + 2 * BAUD) m_idx = 0;
`endif
    endtask

    // Drive one 8N1 character starting at a negedge. rdy_pre is cmd_rdy one
    // clock before the character's last clock; clr_last raises clr_cmd_rdy
    // for exactly that last clock.
    task automatic send_byte(input logic [7:0] d, input logic stop_ok,
                             input logic clr_last, output logic rdy_pre);
        logic [9:0] fr;
        logic       loaded;
        fr      = {stop_ok, d, 1'b0};
        rdy_pre = 1'b0;
        for (int n = 0; n < FRAME; n++) begin
            rx = fr[n / BAUD];
            if (n == FRAME - 1) begin
                rdy_pre = cmd_rdy;
                if (clr_last) clr = 1'b1;
            end
            @(negedge clk);
        end
        clr    = 1'b0;
        rx     = 1'b1;
        loaded = 1'b0;
        if (!stop_ok) begin
            m_idx = 0;
        end else begin
            m_sh[m_idx] = d;
            if (m_idx == 2) begin
                if (!m_rdy || clr_last) begin
                    m_cmd  = {m_sh[0], m_sh[1], m_sh[2]};
                    m_rdy  = 1'b1;
                    loaded = 1'b1;
                end
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (clr_last && !loaded) m_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic clr_last,
                              output logic rdy_pre);
        logic dummy;
        send_byte(b0, 1'b1, 1'b0, dummy);
        idle(2);
        send_byte(b1, 1'b1, 1'b0, dummy);
        idle(1);
        send_byte(b2, 1'b1, clr_last, rdy_pre);
    endtask

    task automatic clear_cmd();
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_rdy = 1'b0;
        check_state("clr");
    endtask

    function automatic logic tx_expect(input logic [7:0] d, input int n);
        if (n < BAUD) return 1'b0;
        if (n < 9 * BAUD) return d[n / BAUD - 1];
        return 1'b1;
    endfunction

    // Request a response byte and compare TX/resp_sent every clock for 100
    // clocks. With probe set, extra requests land at clock 40 (mid-byte) and
    // at clock 81 (while resp_sent is high); both must be ignored.
    task automatic tx_check(input logic [7:0] d, input logic probe);
        resp_data = d;
        send      = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int n = 0; n < 100; n++) begin
            check($sformatf("tx@%0d", n), {31'h0, tx}, {31'h0, tx_expect(d, n)});
            check($sformatf("resp_sent@%0d", n), {31'h0, resp_sent}, {31'h0, (n == FRAME)});
            resp_data = ~d;
            send      = probe && (n == 39 || n == FRAME);
            @(negedge clk);
        end
        send = 1'b0;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic pre;
        rst_n     = 1'b0;
        rx        = 1'b1;
        clr       = 1'b0;
        send      = 1'b0;
        resp_data = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
        check_state("rst");
        rst_n = 1'b1;
        idle(5);

        // 1: basic command, latency and clear.
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, pre);
        check("t1_rdy_before_last_clk", {31'h0, pre}, 32'h0);
        check("t1_cmd", {8'h0, cmd}, 32'h123456);
        check_state("t1");
        clear_cmd();
        check("t1_cmd_after_clr", {8'h0, cmd}, 32'h123456);

        // 2: drop while pending, then load in the same cycle as the clear.
        send_frame(8'h12, 8'h34, 8'h56, 1'b0, pre);
        check_state("t2a");
        send_frame(8'hAA, 8'hBB, 8'hCC, 1'b0, pre);
        check("t2_dropped_cmd", {8'h0, cmd}, 32'h123456);
        check_state("t2b");
        send_frame(8'h01, 8'h02, 8'h03, 1'b1, pre);
        check("t2_cmd", {8'h0, cmd}, 32'h010203);
        check("t2_rdy", {31'h0, cmd_rdy}, 32'h1);
        check_state("t2c");
        idle(4);
        check_state("t2d");

        // 3: response byte with ignored requests.
        tx_check(8'hA5, 1'b1);
        check_state("t3");

        // 4: framing error mid-frame resets the byte index.
        clear_cmd();
        send_byte(8'h11, 1'b1, 1'b0, pre);
        idle(2);
        send_byte(8'h5E, 1'b0, 1'b0, pre);
        idle(12);
        send_frame(8'h22, 8'h33, 8'h44, 1'b0, pre);
        check("t4_cmd", {8'h0, cmd}, 32'h223344);
        check_state("t4");

        // 6: long inter-byte gap.
        clear_cmd();
        send_byte(8'h77, 1'b1, 1'b0, pre);
        idle(300);
        send_frame(8'h01, 8'h02, 8'h03, 1'b0, pre);
`ifdef UART_COMM_TIMEOUT_EN
        check("t6_cmd", {8'h0, cmd}, 32'h010203);
`else
        check("t6_cmd", {8'h0, cmd}, 32'h770102);
`endif
        check_state("t6");

        // Randomised full-duplex traffic.
        for (int it = 0; it < 8; it++) begin
            fork
                begin
                    for (int b = 0; b < 3; b++) begin
                        logic bad;
                        logic rp;
                        bad = ($urandom_range(0, 7) == 0);
                        send_byte(8'($urandom), !bad, 1'b0, rp);
                        check_state("rnd_rx");
                        idle(bad ? 12 : $urandom_range(0, 4));
                    end
                end
                begin
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    tx_check(8'($urandom), 1'b0);
                end
            join
            if ($urandom_range(0, 1) == 1) clear_cmd();
        end

        // 5: start-bit glitch, then reset in the middle of TX and a partial frame.
        idle(10);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check_state("t5_glitch");
        send_byte(8'h99, 1'b1, 1'b0, pre);
        resp_data = 8'h3C;
        send      = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_tx_busy", {31'h0, tx}, {31'h0, tx_expect(8'h3C, 30)});
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_rst_tx", {31'h0, tx}, 32'h1);
        check("t5_rst_resp_sent", {31'h0, resp_sent}, 32'h0);
        check_state("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 90; n++) begin
            check("t5_tx_idle", {31'h0, tx}, 32'h1);
            check("t5_no_resp_sent", {31'h0, resp_sent}, 32'h0);
            @(negedge clk);
        end
        send_frame(8'h5A, 8'h5B, 8'h5C, 1'b0, pre);
        check("t5_cmd_after_rst", {8'h0, cmd}, 32'h5A5B5C);
        check_state("t5_after");
        tx_check(8'h81, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // The receiver reaction time assumed by the latency checks above.
    initial begin
        if (SYNC_LAT + BAUD / 2 + 9 * BAUD + 1 != FRAME) begin
            $display("FAIL latency_assumption: got=%0d expected=%0d", SYNC_LAT + BAUD / 2 + 9 * BAUD + 1, FRAME);
        end
    end

endmodule
